// File: rtl/ct_load_ctrl.sv
// Ciphertext loader: packs 32-bit bus words into W-bit ct memory words and writes them in order.
// Optional trailer checksum compare is enabled by defining CT_LOAD_CHK_EN.
`ifndef N
`define N 47
`endif
`ifndef M
`define M 79
`endif
`ifndef DIGIT
`define DIGIT 4
`endif

module ct_load_ctrl #(
  parameter int n     = `N,
  parameter int m     = `M,
  parameter int digit = `DIGIT,
  localparam int W  = m * digit,
  localparam int D  = (n + digit - 1) / digit,
  localparam int K  = (W + 31) / 32,
  localparam int AW = (D > 1) ? $clog2(D) : 1,
  localparam int CW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  input  logic [31:0]   s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [AW-1:0] ct_addr,
  output logic [W-1:0]  ct_dout,
  output logic          ct_rw,
  output logic          busy,
  output logic          done,
  output logic          error
);

`ifdef CT_LOAD_CHK_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] chunk_q, chunk_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  buf_q, buf_d;
  logic          s_ready_q, s_ready_d;
  logic          ct_rw_q, ct_rw_d;
  logic [AW-1:0] ct_addr_q, ct_addr_d;
  logic [W-1:0]  ct_dout_q, ct_dout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          xfer;
`ifdef CT_LOAD_CHK_EN
  logic [31:0]   chk_q, chk_d;
  logic          error_q, error_d;
`endif

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
`ifdef CT_LOAD_CHK_EN
    chk_d   = chk_q;
    error_d = error_q;
`endif
    xfer = s_valid && s_ready_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RECV;
          chunk_d = '0;
          addr_d  = '0;
          buf_d   = '0;
`ifdef CT_LOAD_CHK_EN
          chk_d   = '0;
          error_d = 1'b0;
`endif
        end
      end
      RECV: begin
        if (xfer) begin
          // Chunk j lands at bits [32j+31:32j]; anything at or above W is dropped.
          for (int unsigned i = 0; i < W; i++) begin
            if ((i / 32) == 32'(chunk_q)) buf_d[i] = s_data[i[4:0]];
          end
`ifdef CT_LOAD_CHK_EN
          chk_d = chk_q ^ s_data;
`endif
          if (chunk_q == CW'(K - 1)) state_d = WRITE;
          else chunk_d = chunk_q + 1'b1;
        end
      end
      WRITE: begin
        if (addr_q == AW'(D - 1)) begin
`ifdef CT_LOAD_CHK_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          addr_d  = addr_q + 1'b1;
          chunk_d = '0;
          buf_d   = '0;
          state_d = RECV;
        end
      end
`ifdef CT_LOAD_CHK_EN
      CHK: begin
        if (xfer) begin
          error_d = (s_data != chk_q);
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered against the next state so they line up with it.
`ifdef CT_LOAD_CHK_EN
    s_ready_d = (state_d == RECV) || (state_d == CHK);
`else
    s_ready_d = (state_d == RECV);
`endif
    ct_rw_d   = (state_d == WRITE);
    ct_addr_d = ct_rw_d ? addr_d : '0;
    ct_dout_d = ct_rw_d ? buf_d : '0;
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q   <= IDLE;
      chunk_q   <= '0;
      addr_q    <= '0;
      buf_q     <= '0;
      s_ready_q <= 1'b0;
      ct_rw_q   <= 1'b0;
      ct_addr_q <= '0;
      ct_dout_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CT_LOAD_CHK_EN
      chk_q     <= '0;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      chunk_q   <= chunk_d;
      addr_q    <= addr_d;
      buf_q     <= buf_d;
      s_ready_q <= s_ready_d;
      ct_rw_q   <= ct_rw_d;
      ct_addr_q <= ct_addr_d;
      ct_dout_q <= ct_dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef CT_LOAD_CHK_EN
      chk_q     <= chk_d;
      error_q   <= error_d;
`endif
    end
  end

  assign s_ready = s_ready_q;
  assign ct_rw   = ct_rw_q;
  assign ct_addr = ct_addr_q;
  assign ct_dout = ct_dout_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef CT_LOAD_CHK_EN
  assign error   = error_q;
`else
  assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_ct_load_ctrl.sv
// Bench for ct_load_ctrl (n=47, m=79, digit=4): expected memory words are rebuilt from the
// stream of accepted bus words and compared against every ct write.
module tb_ct_load_ctrl;
  localparam int W  = 316;
  localparam int D  = 12;
  localparam int K  = 10;
  localparam int AW = 4;
`ifdef CT_LOAD_CHK_EN
  localparam int EXP_LAT = 134;
`else
  localparam int EXP_LAT = 133;
`endif

  logic          clk = 1'b0;
  logic          rst_b = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [AW-1:0] ct_addr;
  logic [W-1:0]  ct_dout;
  logic          ct_rw;
  logic          busy;
  logic          done;
  logic          error;

  ct_load_ctrl #(.n(47), .m(79), .digit(4)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ct_addr(ct_addr), .ct_dout(ct_dout), .ct_rw(ct_rw),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] sent[$];
  int          wr_cnt = 0;
  bit          in_load = 1'b0;
  bit          lat_chk = 1'b0;
  int          start_cyc = 0;
  int          done_cnt = 0;
  logic [W-1:0] dut_mem[D];
  logic [W-1:0] mem_a[D];

  always @(posedge clk) cyc = cyc + 1;

  function automatic void check(string name, bit ok, logic [335:0] act, logic [335:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] pack(int w);
    logic [K*32-1:0] t;
    for (int k = 0; k < K; k++) t[k*32 +: 32] = sent[w*K + k];
    return t[W-1:0];
  endfunction

  function automatic logic [31:0] gen(int mode, int i);
    case (mode)
      0:       return 32'(i);
      1:       return 32'(i * 3 + 7);
      2:       return 32'(i) ^ 32'h5A5A5A5A;
      3:       return ~32'(i);
      default: return 32'hA5A5A5A5;
    endcase
  endfunction

  function automatic logic [31:0] sent_xor();
    logic [31:0] x = '0;
    foreach (sent[i]) x ^= sent[i];
    return x;
  endfunction

  // Per-cycle compare of all outputs against the stream model.
  always @(negedge clk) begin
    if (ct_rw) begin
      check("rw_while_ready", !s_ready, s_ready, 0);
      check("rw_outside_load", in_load, in_load, 1);
      if (wr_cnt < D && sent.size() >= (wr_cnt + 1) * K) begin
        check("ct_addr", ct_addr == AW'(wr_cnt), ct_addr, wr_cnt);
        check("ct_dout", ct_dout == pack(wr_cnt), ct_dout, pack(wr_cnt));
        dut_mem[wr_cnt] = ct_dout;
      end else begin
        check("write_unexpected", 1'b0, wr_cnt, sent.size());
      end
      wr_cnt++;
    end else begin
      check("idle_bus_zero", ct_addr == '0 && ct_dout == '0, {ct_addr, ct_dout}, 0);
    end
    check("busy", busy == in_load, busy, in_load);
    if (done) begin
      check("done_in_load", in_load, in_load, 1);
      check("write_count", wr_cnt == D, wr_cnt, D);
      if (lat_chk) check("latency", cyc - start_cyc == EXP_LAT, cyc - start_cyc, EXP_LAT);
      done_cnt++;
      in_load = 1'b0;
    end
  end

  task automatic check_zero(input string name);
    check(name, {s_ready, ct_rw, ct_addr, ct_dout, busy, done, error} == '0,
          {s_ready, ct_rw, ct_addr, ct_dout, busy, done, error}, 0);
  endtask

  task automatic do_start(input bit lat);
    sent.delete();
    wr_cnt = 0;
    lat_chk = lat;
    foreach (dut_mem[d]) dut_mem[d] = '0;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    in_load = 1'b1;
  endtask

  task automatic send_words(input int cnt, input int mode, input bit toggle, input int glitch);
    int i = 0;
    int budget = 0;
    bit ph = 1'b1;
    bit gl = 1'b0;
    while (i < cnt && budget < cnt * 4 + 50) begin
      s_valid = toggle ? ph : 1'b1;
      ph = !ph;
      s_data = s_valid ? gen(mode, i) : 32'hDEADBEEF;
      start = (i == glitch) && !gl;
      if (start) gl = 1'b1;
      @(negedge clk);
      if (s_valid && s_ready) begin
        sent.push_back(s_data);
        i++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      budget++;
    end
    s_valid = 1'b0;
    check("send_timeout", i == cnt, i, cnt);
  endtask

  task automatic send_trailer(input logic [31:0] v);
    bit acc = 1'b0;
    int budget = 0;
    while (!acc && budget < 20) begin
      s_valid = 1'b1;
      s_data = v;
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      budget++;
    end
    s_valid = 1'b0;
    check("trailer_timeout", acc, acc, 1);
  endtask

  task automatic wait_done(input int budget);
    int dc = done_cnt;
    int t = 0;
    while (done_cnt == dc && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    check("done_timeout", done_cnt != dc, t, budget);
  endtask

  task automatic finish_load();
`ifdef CT_LOAD_CHK_EN
    send_trailer(sent_xor());
`endif
    wait_done(300);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_b = 1'b0;
    @(posedge clk); #1;

    // Incrementing words, valid held high.
    do_start(1'b1);
    send_words(120, 0, 1'b0, -1);
    finish_load();
    check("w0_lo", dut_mem[0][31:0] == 32'd0, dut_mem[0][31:0], 0);
    check("w0_w1", dut_mem[0][63:32] == 32'd1, dut_mem[0][63:32], 1);
    check("w0_top", dut_mem[0][315:288] == 28'd9, dut_mem[0][315:288], 9);
    check("w11_lo", dut_mem[11][31:0] == 32'd110, dut_mem[11][31:0], 110);
    check("w11_w2", dut_mem[11][95:64] == 32'd112, dut_mem[11][95:64], 112);
    foreach (dut_mem[d]) mem_a[d] = dut_mem[d];

    // Same data, valid toggling.
    do_start(1'b0);
    send_words(120, 0, 1'b1, -1);
    finish_load();
    for (int d = 0; d < D; d++) check("toggle_mem", dut_mem[d] == mem_a[d], dut_mem[d], mem_a[d]);

    // Stray start while receiving address 5.
    do_start(1'b1);
    send_words(120, 1, 1'b0, 55);
    finish_load();

    // Reset after the 60th word, then a fresh load.
    do_start(1'b0);
    send_words(60, 2, 1'b0, -1);
    #2;
    rst_b = 1'b1;
    in_load = 1'b0;
    #1;
    check_zero("abort_outputs");
    check("abort_writes", wr_cnt == 5, wr_cnt, 5);
    dc = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt == dc, done_cnt, dc);
    do_start(1'b1);
    send_words(120, 3, 1'b0, -1);
    finish_load();

`ifdef CT_LOAD_CHK_EN
    do_start(1'b1);
    send_words(120, 4, 1'b0, -1);
    send_trailer(32'h00000000);
    wait_done(20);
    check("chk_ok_error", error == 1'b0, error, 0);
    do_start(1'b1);
    send_words(120, 4, 1'b0, -1);
    send_trailer(32'h00000001);
    wait_done(20);
    check("chk_bad_error", error == 1'b1, error, 1);
    repeat (4) @(posedge clk);
    #1;
    check("chk_error_held", error == 1'b1, error, 1);
    do_start(1'b0);
    check("chk_error_cleared", error == 1'b0, error, 0);
    send_words(120, 0, 1'b0, -1);
    finish_load();
    check("chk_final_error", error == 1'b0, error, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
